comp4b: RTL and testbench
=========================

Name: comp4b

Overview:
comp4b is a registered magnitude comparator. It compares two WIDTH-bit operands A and B and reports exactly one of less-than, greater-than or equal. Operands are captured on a valid strobe and the result appears one clock later. It sits on datapath compare/branch-decision paths where a clean, glitch-free flag set is needed.

Parameters:
WIDTH, 4, operand width in bits (minimum 1).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
l  output  1  registered flag: A < B.
g  output  1  registered flag: A > B.
e  output  1  registered flag: A == B.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
in_valid  input  1  capture strobe; A, B and signed_mode are sampled when high.
signed_mode  input  1  0 = unsigned compare; 1 = two's-complement signed compare.
out_valid  output  1  high for one cycle when l/g/e carry a new result.

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-operation): l=0, g=0, e=0, out_valid=0 immediately. State stays cleared while rst_n is low. The first capture occurs on the first rising edge after rst_n deasserts with in_valid high.
- Capture: on a rising clk edge with in_valid=1, the block computes the compare from the current A, B and signed_mode and registers it.
  - Latency is 1 cycle: the result is visible after that edge.
  - out_valid=1 for that cycle.
- Hold: on an edge with in_valid=0, l/g/e keep their last values and out_valid=0.
- Back-to-back captures (in_valid high on consecutive edges) are supported at full throughput, one result per cycle. There is no backpressure.
- Unsigned mode: the operands are treated as 0..2^WIDTH-1.
  - l = A<B, g = A>B, e = A==B.
- Signed mode: the operands are treated as two's complement, -2^(WIDTH-1)..2^(WIDTH-1)-1. The flags have the same meaning.
- Invariant: after any capture, exactly one of l, g, e is 1. Before the first capture after reset, all three are 0.
- e does not depend on signed_mode.
- Outputs come directly from flops, with no combinational path from inputs to l/g/e/out_valid.
- Input changes while in_valid=0 have no effect on the outputs.
- Boundaries, WIDTH=4:
  - A=0,B=0 gives e.
  - A=15,B=0 unsigned gives g; signed (-1 vs 0) gives l.
  - A=8,B=7 unsigned gives g; signed (-8 vs 7) gives l.

Test Plan:
1. Reset: assert rst_n=0 mid-run with l=1 already registered -> l,g,e,out_valid go to 0 immediately, without waiting for a clock edge; they stay 0 until the first valid capture after release.
2. Less-than sweep, unsigned: A=1 with B=2,3,4,5,6 on consecutive cycles with in_valid=1 -> l=1,g=0,e=0 one cycle after each capture, out_valid=1 each cycle.
3. Greater-than and equal, unsigned: A=5 with B=0..4 -> g=1 each time. Then (1,1),(2,2),(3,3),(4,4),(5,5) -> e=1 each time.
4. Mixed unsigned: (8,5) -> g. (4,9) -> l. (2,10) -> l. (1,2) -> l. One flag exactly per result.
5. Signed mode: (8,5) -> l. (15,0) -> l. (7,8) -> g. (15,15) -> e. The same operands with signed_mode=0 give g, g, l, e respectively.
6. Hold: capture (5,3) -> g=1. Then drop in_valid and drive A=0,B=9 for 3 cycles -> g stays 1 and out_valid=0 throughout.

Source files
------------

// File: rtl/comp4b.sv
// ============================================================================
// Module   : comp4b
// Brief    : Registered magnitude comparator (unsigned / two's-complement).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             signed_mode,
    output logic             l,
    output logic             g,
    output logic             e,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;
    logic             w_lt;
    logic             w_gt;
    logic             w_eq;

    logic             r_l;
    logic             r_g;
    logic             r_e;
    logic             r_out_valid;

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    always_comb begin
        w_flip          = '0;
        w_flip[WIDTH-1] = signed_mode;
    end

    assign w_a_key = A ^ w_flip;
    assign w_b_key = B ^ w_flip;

    assign w_eq = (A == B);
    assign w_lt = (w_a_key < w_b_key);
    assign w_gt = ~w_eq & ~w_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l         <= 1'b0;
            r_g         <= 1'b0;
            r_e         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_l <= w_lt;
                r_g <= w_gt;
                r_e <= w_eq;
            end
        end
    end

    assign l         = r_l;
    assign g         = r_g;
    assign e         = r_e;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_comp4b.sv
// ============================================================================
// Module   : tb_comp4b
// Brief    : Table-driven, scoreboarded self-checking bench for comp4b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp4b;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       lge;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             signed_mode;
    logic             l;
    logic             g;
    logic             e;
    logic             out_valid;

    int         checks;
    int         errors;
    logic [2:0] sb_q[$];
    logic [2:0] held;
    vec_t       vecs[$];

    comp4b #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .l          (l),
        .g          (g),
        .e          (e),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: interpret operands as integers.
    function automatic logic [2:0] model(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic s);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (s && ia >= 2**(WIDTH-1)) ia = ia - 2**WIDTH;
        if (s && ib >= 2**(WIDTH-1)) ib = ib - 2**WIDTH;
        if (ia < ib)      return 3'b100;
        else if (ia > ib) return 3'b010;
        else              return 3'b001;
    endfunction

    // One clock: drive on negedge, check 1 time unit after the rising edge.
    task automatic step(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s, input logic v,
                        input logic [2:0] exp);
        logic [2:0] want;
        @(negedge clk);
        A           = a;
        B           = b;
        signed_mode = s;
        in_valid    = v;
        if (v) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        chk({name, ".out_valid"}, {3'b000, out_valid}, {3'b000, v});
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                want = 3'bxxx;
            end else begin
                want = sb_q.pop_front();
            end
            held = want;
        end else begin
            want = held;
        end
        chk({name, ".lge"}, {1'b0, l, g, e}, {1'b0, want});
    endtask

    task automatic add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [2:0] lge);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.lge = lge;
        vecs.push_back(v);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        held        = 3'b000;
        rst_n       = 1'b0;
        A           = '0;
        B           = '0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;

        // Expected flags {l,g,e} written out by hand.
        for (int i = 2; i <= 6; i++) add(4'd1, 4'(i), 1'b0, 3'b100);
        for (int i = 0; i <= 4; i++) add(4'd5, 4'(i), 1'b0, 3'b010);
        for (int i = 1; i <= 5; i++) add(4'(i), 4'(i), 1'b0, 3'b001);
        add(4'd8, 4'd5, 1'b0, 3'b010);
        add(4'd4, 4'd9, 1'b0, 3'b100);
        add(4'd2, 4'd10, 1'b0, 3'b100);
        add(4'd1, 4'd2, 1'b0, 3'b100);
        add(4'd8, 4'd5, 1'b1, 3'b100);
        add(4'd15, 4'd0, 1'b1, 3'b100);
        add(4'd7, 4'd8, 1'b1, 3'b010);
        add(4'd15, 4'd15, 1'b1, 3'b001);
        add(4'd8, 4'd5, 1'b0, 3'b010);
        add(4'd15, 4'd0, 1'b0, 3'b010);
        add(4'd7, 4'd8, 1'b0, 3'b100);
        add(4'd15, 4'd15, 1'b0, 3'b001);
        add(4'd0, 4'd0, 1'b0, 3'b001);
        add(4'd0, 4'd0, 1'b1, 3'b001);
        add(4'd8, 4'd7, 1'b0, 3'b010);
        add(4'd8, 4'd7, 1'b1, 3'b100);

        #12;
        chk("reset_state", {l, g, e, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset", 4'd3, 4'd1, 1'b0, 1'b0, 3'b000);

        // Back-to-back table captures at full throughput.
        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                               vecs[i].s, 1'b1, vecs[i].lge);

        // Hold: inputs move while in_valid is low.
        step("hold_cap", 4'd5, 4'd3, 1'b0, 1'b1, 3'b010);
        for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 4'd0, 4'd9, 1'b0, 1'b0, 3'b000);

        // Asynchronous reset in the middle of a cycle with l registered.
        step("pre_reset_l", 4'd1, 4'd2, 1'b0, 1'b1, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {l, g, e, out_valid}, 4'b0000);
        in_valid = 1'b1;
        A        = 4'd9;
        B        = 4'd1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("held_in_reset", {l, g, e, out_valid}, 4'b0000);
        end
        held = 3'b000;
        sb_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("idle_after_release", 4'd9, 4'd1, 1'b0, 1'b0, 3'b000);
        step("first_after_release", 4'd9, 4'd1, 1'b0, 1'b1, 3'b010);

        // Random captures against the integer model, with gaps.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rs;
            logic             rv;
            ra = WIDTH'($urandom_range(0, 15));
            rb = WIDTH'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            step($sformatf("rand%0d", i), ra, rb, rs, rv, model(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
